joy_cond: RTL and testbench

- Parametrised per-player joystick conditioner; next generation of the single-player opposing-direction resolver in the arcade top level.
- Applies, per player and in this order: optional 90° rotation, per-bit debounce, selectable SOCD (opposing-direction) resolution and optional 4-way diagonal restriction.
- Sits between the keyboard/gamepad merge logic and the game core's active-low control inputs; the core inverts outputs itself.

---
 rtl/joy_cond_if.sv | 21 ++
 rtl/joy_cond.sv | 174 +++++++++++++++++
 tb/tb_joy_cond.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/joy_cond_if.sv
// Joystick conditioner bus: raw directions and mode controls in, conditioned directions out.
interface joy_cond_if #(
  parameter int PLAYERS = 2
);
  logic [4*PLAYERS-1:0] dir_in;
  logic                 rotate;
  logic [1:0]           socd_mode;
  logic                 four_way;
  logic [4*PLAYERS-1:0] dir_out;
  logic [PLAYERS-1:0]   change;

  modport master (
    output dir_in, rotate, socd_mode, four_way,
    input  dir_out, change
  );

  modport slave (
    input  dir_in, rotate, socd_mode, four_way,
    output dir_out, change
  );
endinterface

// File: rtl/joy_cond.sv
// Per-player joystick conditioner: rotation, per-bit debounce, opposing-direction
// (SOCD) resolution and optional 4-way diagonal suppression. Outputs active high.
// Per-player packing: [3]=up, [2]=down, [1]=left, [0]=right.
module joy_cond #(
  parameter int PLAYERS = 2,
  parameter int DEB_LEN = 1
) (
  input  logic       clk_sys,
  input  logic       reset,
  joy_cond_if.slave  io
);

  typedef enum logic {
    AXIS_V = 1'b0,
    AXIS_H = 1'b1
  } axis_t;

  localparam logic [3:0] DEB_LAST = 4'(DEB_LEN - 1);

  logic [PLAYERS-1:0][3:0]      s1;
  logic [PLAYERS-1:0][3:0]      s1_next;
  logic [PLAYERS-1:0][3:0]      db;
  logic [PLAYERS-1:0][3:0]      db_d;
  logic [PLAYERS-1:0][3:0]      np;
  logic [PLAYERS-1:0][3:0][3:0] cnt;
  logic [PLAYERS-1:0][1:0]      last_h;
  logic [PLAYERS-1:0][1:0]      last_v;
  logic [PLAYERS-1:0][1:0]      last_h_next;
  logic [PLAYERS-1:0][1:0]      last_v_next;
  logic [PLAYERS-1:0][3:0]      resolved;
  logic [PLAYERS-1:0][3:0]      dout;
  logic [PLAYERS-1:0]           chg;
  axis_t                        axis_last [PLAYERS];
  axis_t                        axis_next [PLAYERS];

  // Pair memory update: press is {first,second} new-press bits, result is the
  // most recent single press (10 / 01), 00 when both arrived together.
  function automatic logic [1:0] press_mem(input logic [1:0] press, input logic [1:0] last);
    logic [1:0] res;
    case (press)
      2'b00:   res = last;
      2'b11:   res = 2'b00;
      default: res = press;
    endcase
    return res;
  endfunction

  // Opposing-direction resolution for one axis pair {first,second}.
  function automatic logic [1:0] socd_pair(input logic [1:0] held, input logic [1:0] last,
                                           input logic [1:0] mode, input logic vert);
    logic [1:0] res;
    res = held;
    if (held == 2'b11) begin
      case (mode)
        2'b00:   res = last;
        2'b01:   res = 2'b00;
        2'b10:   res = (last == 2'b00) ? 2'b00 : ~last;
        default: res = vert ? 2'b10 : 2'b00;
      endcase
    end
    return res;
  endfunction

  // Stage 1 input mapping; rotated cabinet turns the stick a quarter turn.
  always_comb begin
    s1_next = '0;
    for (int unsigned p = 0; p < PLAYERS; p++) begin
      if (io.rotate) begin
        s1_next[p] = {io.dir_in[4*p+1], io.dir_in[4*p], io.dir_in[4*p+2], io.dir_in[4*p+3]};
      end else begin
        s1_next[p] = io.dir_in[4*p +: 4];
      end
    end
  end

  // Capture register and per-bit debounce; db only moves after DEB_LEN stable cycles.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      s1   <= '0;
      db   <= '0;
      db_d <= '0;
      cnt  <= '0;
    end else begin
      s1   <= s1_next;
      db_d <= db;
      for (int unsigned p = 0; p < PLAYERS; p++) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (s1[p][b] == db[p][b]) begin
            cnt[p][b] <= '0;
          end else if (cnt[p][b] == DEB_LAST) begin
            db[p][b]  <= s1[p][b];
            cnt[p][b] <= '0;
          end else begin
            cnt[p][b] <= cnt[p][b] + 4'd1;
          end
        end
      end
    end
  end

  // Resolver: press memory, SOCD per axis, axis tracking and diagonal suppression.
  // Everything here uses the post-update memory so a press acts in its own cycle.
  always_comb begin
    logic [1:0] h;
    logic [1:0] v;
    logic       h_press;
    logic       v_press;
    np          = '0;
    last_h_next = '0;
    last_v_next = '0;
    resolved    = '0;
    h           = '0;
    v           = '0;
    h_press     = 1'b0;
    v_press     = 1'b0;
    for (int unsigned p = 0; p < PLAYERS; p++) begin
      axis_next[p]   = axis_last[p];
      np[p]          = db[p] & ~db_d[p];
      last_h_next[p] = press_mem(np[p][1:0], last_h[p]);
      last_v_next[p] = press_mem(np[p][3:2], last_v[p]);
      h              = socd_pair(db[p][1:0], last_h_next[p], io.socd_mode, 1'b0);
      v              = socd_pair(db[p][3:2], last_v_next[p], io.socd_mode, 1'b1);
      h_press        = |np[p][1:0];
      v_press        = |np[p][3:2];
      if (h_press && !v_press) begin
        axis_next[p] = AXIS_H;
      end else if (v_press && !h_press) begin
        axis_next[p] = AXIS_V;
      end
      if (io.four_way && (h != 2'b00) && (v != 2'b00)) begin
        if (axis_next[p] == AXIS_H) begin
          v = 2'b00;
        end else begin
          h = 2'b00;
        end
      end
      resolved[p] = {v, h};
    end
  end

  // Press memory and axis-of-last-press state registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      last_h <= '0;
      last_v <= '0;
      for (int unsigned p = 0; p < PLAYERS; p++) begin
        axis_last[p] <= AXIS_V;
      end
    end else begin
      last_h <= last_h_next;
      last_v <= last_v_next;
      for (int unsigned p = 0; p < PLAYERS; p++) begin
        axis_last[p] <= axis_next[p];
      end
    end
  end

  // Output register; change flags the cycle in which a new value becomes visible.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dout <= '0;
      chg  <= '0;
    end else begin
      dout <= resolved;
      for (int unsigned p = 0; p < PLAYERS; p++) begin
        chg[p] <= (resolved[p] != dout[p]);
      end
    end
  end

  assign io.dir_out = dout;
  assign io.change  = chg;

endmodule

// File: tb/tb_joy_cond.sv
// Self-checking bench for joy_cond: two instances (DEB_LEN 1 and 4) share stimulus
// and are compared every cycle against a behavioural model, plus directed spot checks.
module tb_joy_cond;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic       rot = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       fw = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  joy_cond_if #(.PLAYERS(2)) io0 ();
  joy_cond_if #(.PLAYERS(2)) io1 ();

  assign io0.dir_in    = din;
  assign io0.rotate    = rot;
  assign io0.socd_mode = mode;
  assign io0.four_way  = fw;
  assign io1.dir_in    = din;
  assign io1.rotate    = rot;
  assign io1.socd_mode = mode;
  assign io1.four_way  = fw;

  joy_cond #(.PLAYERS(2), .DEB_LEN(1)) dut0 (.clk_sys(clk), .reset(rst), .io(io0));
  joy_cond #(.PLAYERS(2), .DEB_LEN(4)) dut1 (.clk_sys(clk), .reset(rst), .io(io1));

  // Model state, indexed [instance][player]. Press memory: 0 none, 1 up/left, 2 down/right.
  int         deb_len [2] = '{1, 4};
  logic [3:0] m_s1  [2][2];
  logic [3:0] m_db  [2][2];
  logic [3:0] m_dbd [2][2];
  int         m_run [2][2][4];
  int         m_lh  [2][2];
  int         m_lv  [2][2];
  bit         m_axh [2][2];
  logic [3:0] m_out [2][2];
  bit         m_chg [2][2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int remember(input bit pa, input bit pb, input int last);
    if (pa && pb) return 0;
    if (pa) return 1;
    if (pb) return 2;
    return last;
  endfunction

  // Both opposing directions held -> decide from mode and which was pressed last.
  function automatic logic [1:0] pair_out(input bit a, input bit b, input int last,
                                          input logic [1:0] md, input bit vert);
    if (!(a && b)) return {a, b};
    case (md)
      2'b00:   return (last == 1) ? 2'b10 : (last == 2) ? 2'b01 : 2'b00;
      2'b01:   return 2'b00;
      2'b10:   return (last == 1) ? 2'b01 : (last == 2) ? 2'b10 : 2'b00;
      default: return vert ? 2'b10 : 2'b00;
    endcase
  endfunction

  task automatic model_step();
    logic [3:0] held, np, raw;
    logic [1:0] h, v;
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (rst) begin
          m_s1[i][p] = '0; m_db[i][p] = '0; m_dbd[i][p] = '0;
          m_lh[i][p] = 0; m_lv[i][p] = 0; m_axh[i][p] = 0;
          m_out[i][p] = '0; m_chg[i][p] = 0;
          for (int b = 0; b < 4; b++) m_run[i][p][b] = 0;
        end else begin
          held = m_db[i][p];
          np   = m_db[i][p] & ~m_dbd[i][p];
          m_lh[i][p] = remember(np[1], np[0], m_lh[i][p]);
          m_lv[i][p] = remember(np[3], np[2], m_lv[i][p]);
          h = pair_out(held[1], held[0], m_lh[i][p], mode, 1'b0);
          v = pair_out(held[3], held[2], m_lv[i][p], mode, 1'b1);
          if ((np[1] || np[0]) && !(np[3] || np[2])) m_axh[i][p] = 1;
          else if ((np[3] || np[2]) && !(np[1] || np[0])) m_axh[i][p] = 0;
          if (fw && h != 0 && v != 0) begin
            if (m_axh[i][p]) v = 2'b00;
            else h = 2'b00;
          end
          m_chg[i][p] = ({v, h} != m_out[i][p]);
          m_out[i][p] = {v, h};
          m_dbd[i][p] = m_db[i][p];
          // A bit is accepted once it has disagreed with the filtered value for deb_len cycles.
          for (int b = 0; b < 4; b++) begin
            if (m_s1[i][p][b] != m_db[i][p][b]) begin
              m_run[i][p][b]++;
              if (m_run[i][p][b] >= deb_len[i]) begin
                m_db[i][p][b]  = m_s1[i][p][b];
                m_run[i][p][b] = 0;
              end
            end else begin
              m_run[i][p][b] = 0;
            end
          end
          raw = din[4*p +: 4];
          // Rotated: up<-left, down<-right, left<-down, right<-up.
          if (rot) m_s1[i][p] = {raw[1], raw[0], raw[2], raw[3]};
          else     m_s1[i][p] = raw;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("dir_out0", 32'(io0.dir_out), 32'({m_out[0][1], m_out[0][0]}));
    check("change0",  32'(io0.change),  32'({m_chg[0][1], m_chg[0][0]}));
    check("dir_out1", 32'(io1.dir_out), 32'({m_out[1][1], m_out[1][0]}));
    check("change1",  32'(io1.change),  32'({m_chg[1][1], m_chg[1][0]}));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; din = '0;
    ticks(2);
    check("reset_dir", 32'(io0.dir_out), 32'h0);
    rst = 1'b0;
    ticks(1);
  endtask

  initial begin
    bit seen;
    int waited;
    logic [1:0] socd_modes [3];
    logic [3:0] socd_exp [3];
    socd_modes = '{2'b01, 2'b10, 2'b00};
    socd_exp   = '{4'b0000, 4'b0001, 4'b0010};

    // Reset state
    rst = 1'b1;
    ticks(2);
    check("rst_dir0", 32'(io0.dir_out), 32'h0);
    check("rst_chg1", 32'(io1.change), 32'h0);
    rst = 1'b0;
    ticks(1);

    // Last-wins walk: R, add L, release L
    din = 8'b0000_0001;
    ticks(3);
    check("lw_r", 32'(io0.dir_out[3:0]), 32'h1);
    check("lw_r_chg", 32'(io0.change[0]), 32'h1);
    ticks(7);
    din = 8'b0000_0011;
    ticks(3);
    check("lw_l", 32'(io0.dir_out[3:0]), 32'h2);
    check("lw_l_chg", 32'(io0.change[0]), 32'h1);
    ticks(7);
    din = 8'b0000_0001;
    ticks(3);
    check("lw_rel", 32'(io0.dir_out[3:0]), 32'h1);
    check("lw_rel_chg", 32'(io0.change[0]), 32'h1);

    // SOCD modes with R pressed before L
    for (int m = 0; m < 3; m++) begin
      mode = socd_modes[m];
      do_reset();
      din = 8'b0000_0001;
      ticks(3);
      din = 8'b0000_0011;
      ticks(3);
      check("socd_mode", 32'(io0.dir_out[3:0]), 32'(socd_exp[m]));
    end
    mode = 2'b00;
    do_reset();
    din = 8'b0000_0011;
    ticks(3);
    check("socd_same", 32'(io0.dir_out[3:0]), 32'h0);

    // Debounce (instance with DEB_LEN=4)
    do_reset();
    din = 8'b0000_1000;
    seen = 0;
    for (int k = 0; k < 3; k++) begin tick(); seen |= io1.change[0]; end
    din = '0;
    for (int k = 0; k < 8; k++) begin tick(); seen |= io1.change[0]; end
    check("glitch_dir", 32'(io1.dir_out[3:0]), 32'h0);
    check("glitch_chg", 32'(seen), 32'h0);
    do_reset();
    din = 8'b0000_1000;
    ticks(5);
    check("deb4_early", 32'(io1.dir_out[3:0]), 32'h0);
    ticks(1);
    check("deb4_up", 32'(io1.dir_out[3:0]), 32'h8);

    // Rotation
    do_reset();
    rot = 1'b1;
    din = 8'b1000_0010;
    ticks(3);
    check("rotate", 32'(io0.dir_out), 32'b0001_1000);
    rot = 1'b0;

    // Four-way
    do_reset();
    fw = 1'b1;
    din = 8'b0000_1000;
    ticks(3);
    din = 8'b0000_1001;
    ticks(3);
    check("fw_add_r", 32'(io0.dir_out[3:0]), 32'h1);
    din = 8'b0000_1000;
    ticks(3);
    check("fw_rel_r", 32'(io0.dir_out[3:0]), 32'h8);
    do_reset();
    din = 8'b0000_1001;
    ticks(3);
    check("fw_same", 32'(io0.dir_out[3:0]), 32'h8);
    fw = 1'b0;

    // Reset mid-operation with held inputs
    do_reset();
    din = 8'b0100_1000;
    ticks(8);
    rst = 1'b1;
    ticks(1);
    check("midrst_dir", 32'(io0.dir_out), 32'h0);
    check("midrst_chg", 32'(io0.change), 32'h0);
    rst = 1'b0;
    waited = 0;
    while (io0.dir_out == 8'h00 && waited < 10) begin tick(); waited++; end
    check("midrst_lat", 32'(waited), 32'd3);
    check("midrst_val", 32'(io0.dir_out), 32'h48);
    check("midrst_pulse", 32'(io0.change), 32'h3);

    // Randomised run against the model
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 3) == 0) din = din ^ 8'($urandom);
      rst = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 99) == 0) rot = ~rot;
      if ($urandom_range(0, 59) == 0) fw = ~fw;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
